div_shift_seq: RTL and testbench

DIV_SHIFT_SEQ -- requirements
Module: div_shift_seq

---
 rtl/div_shift_seq.sv | 130 +++++++++++++
 tb/tb_div_shift_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div_shift_seq.sv
// Sequential restoring divider: one quotient bit per cycle, optional two's-complement
// operands with truncation toward zero and a dividend-signed remainder.
module div_shift_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sgn,
    input  logic [N-1:0] dividiendo,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   rem_r;
    logic [N-1:0]   dvd_r;      // dividend bits shift out the top, quotient bits shift in below
    logic [N-1:0]   dvs_r;
    logic           neg_q_r;
    logic           neg_r_r;

    logic [N:0]     rem_sh_s;
    logic [N-1:0]   rem_sub_s;
    logic           fits_s;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;

    function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic s);
        if (s && v[N-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    // Restoring step datapath and operand magnitudes.
    always_comb begin
        rem_sh_s  = {rem_r, dvd_r[N-1]};
        fits_s    = (rem_sh_s >= {1'b0, dvs_r});
        // A fitting difference is always below the divisor, so N bits hold it.
        rem_sub_s = rem_sh_s[N-1:0] - dvs_r;
        a_mag_s   = mag(dividiendo, sgn);
        b_mag_s   = mag(divisor, sgn);
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= {N{1'b0}};
            r       <= {N{1'b0}};
            dz      <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            rem_r   <= {N{1'b0}};
            dvd_r   <= {N{1'b0}};
            dvs_r   <= {N{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == {N{1'b0}}) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                            q       <= {N{1'b1}};
                            r       <= dividiendo;
                            dz      <= 1'b1;
                        end else begin
                            state_r <= CALC;
                            cnt_r   <= CW'(N);
                            rem_r   <= {N{1'b0}};
                            dvd_r   <= a_mag_s;
                            dvs_r   <= b_mag_s;
                            neg_q_r <= sgn & (dividiendo[N-1] ^ divisor[N-1]);
                            neg_r_r <= sgn & dividiendo[N-1];
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r <= fits_s ? rem_sub_s : rem_sh_s[N-1:0];
                    dvd_r <= {dvd_r[N-2:0], fits_s};
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    // Most-negative / -1 lands here as magnitude 2^(N-1) with no negation: wraps.
                    q       <= neg_q_r ? -dvd_r : dvd_r;
                    r       <= neg_r_r ? -rem_r : rem_r;
                    dz      <= 1'b0;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_shift_seq.sv
// Self-checking bench for div_shift_seq at N = 4, 8, 16 against an arithmetic reference.
module tb_div_shift_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        st4, sg4, busy4, done4, dz4;
    logic [3:0]  a4, b4, q4, r4;
    logic        st8, sg8, busy8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;
    logic        st16, sg16, busy16, done16, dz16;
    logic [15:0] a16, b16, q16, r16;

    div_shift_seq #(.N(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .sgn(sg4), .dividiendo(a4), .divisor(b4),
        .busy(busy4), .done(done4), .q(q4), .r(r4), .dz(dz4));
    div_shift_seq #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .sgn(sg8), .dividiendo(a8), .divisor(b8),
        .busy(busy8), .done(done8), .q(q8), .r(r8), .dz(dz8));
    div_shift_seq #(.N(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .sgn(sg16), .dividiendo(a16), .divisor(b16),
        .busy(busy16), .done(done16), .q(q16), .r(r16), .dz(dz16));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s_st, input logic s_sg,
                         input logic [31:0] a, input logic [31:0] b);
        case (w)
            4:       begin st4 = s_st;  sg4 = s_sg;  a4 = a[3:0];   b4 = b[3:0];   end
            8:       begin st8 = s_st;  sg8 = s_sg;  a8 = a[7:0];   b8 = b[7:0];   end
            default: begin st16 = s_st; sg16 = s_sg; a16 = a[15:0]; b16 = b[15:0]; end
        endcase
    endtask

    task automatic sample(input int w, output logic ob, output logic od, output logic oz,
                          output logic [31:0] oq, output logic [31:0] orr);
        case (w)
            4:       begin ob = busy4;  od = done4;  oz = dz4;  oq = {28'd0, q4};  orr = {28'd0, r4};  end
            8:       begin ob = busy8;  od = done8;  oz = dz8;  oq = {24'd0, q8};  orr = {24'd0, r8};  end
            default: begin ob = busy16; od = done16; oz = dz16; oq = {16'd0, q16}; orr = {16'd0, r16}; end
        endcase
    endtask

    // Reference: plain integer division on the operand values, C-style truncation.
    task automatic model(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er, output logic ez);
        longint m, av, bv, qv, rv;
        m  = longint'(1) << w;
        av = longint'(a);
        bv = longint'(b);
        if (bv == 0) begin
            eq = 32'(m - 1); er = a; ez = 1'b1;
        end else begin
            if (s && av >= m / 2) av = av - m;
            if (s && bv >= m / 2) bv = bv - m;
            if (av == -(m / 2) && bv == -1) begin
                qv = m / 2; rv = 0;
            end else begin
                qv = av / bv; rv = av % bv;
            end
            eq = 32'(qv & (m - 1)); er = 32'(rv & (m - 1)); ez = 1'b0;
        end
    endtask

    task automatic run_op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] eq, er, oq, orr;
        logic ez, ob, od, oz;
        int seen, lat;
        model(w, s, a, b, eq, er, ez);
        lat = ez ? 1 : w + 2;
        seen = 0;
        @(negedge clk);
        drive(w, 1'b1, s, a, b);
        for (int e = 1; e <= w + 6 && seen == 0; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) drive(w, 1'b0, s, $urandom, $urandom);
            sample(w, ob, od, oz, oq, orr);
            if (e == 1) check({tag, " busy"}, {31'd0, ob}, 32'd1);
            if (od) seen = e;
        end
        check({tag, " latency"}, 32'(seen), 32'(lat));
        check({tag, " q"}, oq, eq);
        check({tag, " r"}, orr, er);
        check({tag, " dz"}, {31'd0, oz}, {31'd0, ez});
        @(posedge clk);
        #1;
        sample(w, ob, od, oz, oq, orr);
        check({tag, " done_pulse"}, {31'd0, od}, 32'd0);
        check({tag, " busy_idle"}, {31'd0, ob}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        sample(w, ob, od, oz, oq, orr);
        check({tag, " q_hold"}, oq, eq);
    endtask

    initial begin
        logic [31:0] oq, orr, mask, a, b;
        logic ob, od, oz;
        int dseen;
        int widths[3] = '{4, 8, 16};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(widths[i], 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sample(widths[i], ob, od, oz, oq, orr);
            check("reset busy", {31'd0, ob}, 32'd0);
            check("reset done", {31'd0, od}, 32'd0);
            check("reset q", oq, 32'd0);
            check("reset r", orr, 32'd0);
            check("reset dz", {31'd0, oz}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(8, 1'b0, 32'd100, 32'd7, "u100/7");
        run_op(8, 1'b1, 32'h9C, 32'h07, "s-100/7");
        run_op(8, 1'b1, 32'd100, 32'hF9, "s100/-7");
        run_op(8, 1'b0, 32'd55, 32'd0, "u55/0");
        run_op(8, 1'b0, 32'd9, 32'd3, "dz_clear");
        run_op(8, 1'b1, 32'd55, 32'd0, "s55/0");
        run_op(8, 1'b1, 32'h80, 32'hFF, "s80/FF");
        run_op(4, 1'b1, 32'h8, 32'hF, "n4 minneg");
        run_op(16, 1'b1, 32'h8000, 32'hFFFF, "n16 minneg");
        run_op(8, 1'b0, 32'hFF, 32'h01, "uFF/1");

        // Start held through a divide-by-zero DONE cycle must not be taken there.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 32'd55, 32'd0);
        @(posedge clk);
        #1;
        sample(8, ob, od, oz, oq, orr);
        check("dz_hold done", {31'd0, od}, 32'd1);
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        sample(8, ob, od, oz, oq, orr);
        check("start_in_done busy", {31'd0, ob}, 32'd0);
        run_op(8, 1'b0, 32'd100, 32'd7, "after_done");

        // Abort: second start while busy, then reset mid-operation.
        dseen = 0;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            drive(8, (e == 1 || e == 4), 1'b0, (e == 4) ? 32'd17 : 32'd200, (e == 4) ? 32'd5 : 32'd3);
            rst = (e == 6);
            @(posedge clk);
            #1;
            sample(8, ob, od, oz, oq, orr);
            if (od) dseen++;
        end
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        check("abort busy", {31'd0, ob}, 32'd0);
        check("abort done", {31'd0, od}, 32'd0);
        check("abort q", oq, 32'd0);
        check("abort r", orr, 32'd0);
        check("abort dz", {31'd0, oz}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            sample(8, ob, od, oz, oq, orr);
            if (od) dseen++;
        end
        check("abort no_done", 32'(dseen), 32'd0);
        run_op(8, 1'b0, 32'd200, 32'd3, "post_reset 200/3");

        for (int i = 0; i < 3; i++) begin
            mask = (32'd1 << widths[i]) - 32'd1;
            for (int k = 0; k < 20; k++) begin
                a = $urandom & mask;
                b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & mask);
                run_op(widths[i], 1'($urandom_range(0, 1)), a, b, $sformatf("rand n%0d", widths[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
